// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state, grant owner, full-word byte select.
package dmem_port_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;
   localparam logic [3:0] SEL_FULL = 4'b1111;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the arbiter: D and I requester ports plus the shared memory port.
interface dmem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  i_d_req;
   logic                  i_d_wr_en;
   logic [3:0]            i_d_sel;
   logic [ADDR_WIDTH-1:0] i_d_addr;
   logic [DATA_WIDTH-1:0] i_d_wdata;
   logic [DATA_WIDTH-1:0] o_d_rdata;
   logic                  o_d_valid;
   logic                  i_i_req;
   logic [ADDR_WIDTH-1:0] i_i_addr;
   logic [DATA_WIDTH-1:0] o_i_rdata;
   logic                  o_i_valid;
   logic                  o_err;
   logic                  o_mem_req;
   logic                  o_mem_wr_en;
   logic [3:0]            o_mem_sel;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic [DATA_WIDTH-1:0] i_mem_rdata;
   logic                  i_mem_valid;

   modport slave (
      input  i_d_req, i_d_wr_en, i_d_sel, i_d_addr, i_d_wdata, i_i_req, i_i_addr,
      input  i_mem_rdata, i_mem_valid,
      output o_d_rdata, o_d_valid, o_i_rdata, o_i_valid, o_err,
      output o_mem_req, o_mem_wr_en, o_mem_sel, o_mem_addr, o_mem_wdata
   );

   modport master (
      output i_d_req, i_d_wr_en, i_d_sel, i_d_addr, i_d_wdata, i_i_req, i_i_addr,
      output i_mem_rdata, i_mem_valid,
      input  o_d_rdata, o_d_valid, o_i_rdata, o_i_valid, o_err,
      input  o_mem_req, o_mem_wr_en, o_mem_sel, o_mem_addr, o_mem_wdata
   );
endinterface

// File: rtl/dmem_port_arbiter_timeout_cnt.sv
// arb_timeout_cnt: per-transaction BUSY-cycle counter; expire marks the TIMEOUT-th BUSY cycle.
module arb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int unsigned W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + W'(1);
   end

   assign expire = (count == LAST);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between D (load/store) and I (fetch); D has fixed priority.
// Optional starvation guard for I is enabled by defining ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned TIMEOUT      = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                rst_n,
   dmem_port_arbiter_if.slave bus
);
`ifdef ARB_STARVE_GUARD_EN
   localparam logic GUARD_EN = 1'b1;
`else
   localparam logic GUARD_EN = 1'b0;
`endif
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   state_t        state;
   owner_t        owner;
   logic [SW-1:0] starve;
   logic          busy, force_i, grant_d, grant_i, grant;
   logic          expire, timeout_hit, done;
   logic [DATA_WIDTH-1:0] rdata_out;

   assign busy        = (state == BUSY);
   assign force_i     = GUARD_EN && bus.i_i_req && (starve == SW'(STARVE_LIMIT));
   assign grant_d     = !busy && bus.i_d_req && !force_i;
   assign grant_i     = !busy && bus.i_i_req && (force_i || !bus.i_d_req);
   assign grant       = grant_d || grant_i;
   // Memory completion wins over a coincident timeout.
   assign timeout_hit = busy && expire && !bus.i_mem_valid;
   assign done        = busy && (bus.i_mem_valid || expire);

   arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (grant),
      .enable (busy),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve <= '0;
      else if (!bus.i_i_req || grant_i)
         starve <= '0;
      else if (grant_d)
         starve <= starve + SW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         owner           <= OWN_D;
         bus.o_mem_req   <= 1'b0;
         bus.o_mem_wr_en <= 1'b0;
         bus.o_mem_sel   <= '0;
         bus.o_mem_addr  <= '0;
         bus.o_mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state         <= BUSY;
                  bus.o_mem_req <= 1'b1;
                  if (grant_d) begin
                     owner           <= OWN_D;
                     bus.o_mem_wr_en <= bus.i_d_wr_en;
                     bus.o_mem_sel   <= bus.i_d_sel;
                     bus.o_mem_addr  <= bus.i_d_addr;
                     bus.o_mem_wdata <= bus.i_d_wr_en ? bus.i_d_wdata : '0;
                  end else begin
                     owner           <= OWN_I;
                     bus.o_mem_wr_en <= 1'b0;
                     bus.o_mem_sel   <= SEL_FULL;
                     bus.o_mem_addr  <= bus.i_i_addr;
                     bus.o_mem_wdata <= '0;
                  end
               end
            end
            BUSY: begin
               if (done) begin
                  state           <= IDLE;
                  bus.o_mem_req   <= 1'b0;
                  bus.o_mem_wr_en <= 1'b0;
                  bus.o_mem_sel   <= '0;
                  bus.o_mem_addr  <= '0;
                  bus.o_mem_wdata <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rdata_out     = timeout_hit ? '0 : bus.i_mem_rdata;
   assign bus.o_d_valid = done && (owner == OWN_D);
   assign bus.o_i_valid = done && (owner == OWN_I);
   assign bus.o_d_rdata = bus.o_d_valid ? rdata_out : '0;
   assign bus.o_i_rdata = bus.o_i_valid ? rdata_out : '0;
   assign bus.o_err     = timeout_hit;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter plus timeout, reset and starvation sequences.
module tb_dmem_port_arbiter;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   dmem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16), .STARVE_LIMIT(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic d_req; logic d_wr; logic [3:0] d_sel; logic [31:0] d_addr; logic [31:0] d_wdata;
      logic i_req; logic [31:0] i_addr; logic mv; logic [31:0] mrd;
      logic e_req; logic e_wr; logic [3:0] e_sel; logic [31:0] e_addr; logic [31:0] e_wdata;
      logic e_dv; logic [31:0] e_drd; logic e_iv; logic [31:0] e_ird; logic e_err;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [159:0] pack_exp(input vec_t v);
      return {23'b0, v.e_req, v.e_wr, v.e_sel, v.e_addr, v.e_wdata,
              v.e_dv, v.e_drd, v.e_iv, v.e_ird, v.e_err};
   endfunction

   function automatic logic [159:0] pack_got();
      return {23'b0, bus.o_mem_req, bus.o_mem_wr_en, bus.o_mem_sel, bus.o_mem_addr, bus.o_mem_wdata,
              bus.o_d_valid, bus.o_d_rdata, bus.o_i_valid, bus.o_i_rdata, bus.o_err};
   endfunction

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic d_req, input logic d_wr, input logic [3:0] d_sel,
                        input logic [31:0] d_addr, input logic [31:0] d_wdata,
                        input logic i_req, input logic [31:0] i_addr,
                        input logic mv, input logic [31:0] mrd);
      bus.i_d_req     = d_req;
      bus.i_d_wr_en   = d_wr;
      bus.i_d_sel     = d_sel;
      bus.i_d_addr    = d_addr;
      bus.i_d_wdata   = d_wdata;
      bus.i_i_req     = i_req;
      bus.i_i_addr    = i_addr;
      bus.i_mem_valid = mv;
      bus.i_mem_rdata = mrd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  g;
      bit  quiet_ok;
      bit  exp_i;

      //         d_req wr sel     d_addr        d_wdata       i_req i_addr       mv  mrd          | req wr sel     addr          wdata         dv drd           iv ird           err
      vecs[0]  = '{1, 0, 4'hF, 32'h100, 32'hFFFF0000, 0, 32'h0,  0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[1]  = '{1, 0, 4'hF, 32'h100, 32'hFFFF0000, 0, 32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[2]  = '{1, 0, 4'hF, 32'h100, 32'hFFFF0000, 0, 32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[3]  = '{1, 0, 4'hF, 32'h100, 32'hFFFF0000, 0, 32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[4]  = '{1, 0, 4'hF, 32'h100, 32'hFFFF0000, 0, 32'h0,  1, 32'hDEADBEEF, 1, 0, 4'hF, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0};
      vecs[5]  = '{0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h1234,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[6]  = '{1, 1, 4'h3, 32'h200, 32'hA5A5A5A5, 1, 32'h40, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[7]  = '{1, 1, 4'h3, 32'h200, 32'hA5A5A5A5, 1, 32'h40, 0, 32'h0,        1, 1, 4'h3, 32'h200, 32'hA5A5A5A5, 0, 32'h0,        0, 32'h0,        0};
      vecs[8]  = '{1, 1, 4'h3, 32'h200, 32'hA5A5A5A5, 1, 32'h40, 1, 32'h11111111, 1, 1, 4'h3, 32'h200, 32'hA5A5A5A5, 1, 32'h11111111, 0, 32'h0,        0};
      vecs[9]  = '{0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h40, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[10] = '{0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h40, 0, 32'h0,        1, 0, 4'hF, 32'h40,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[11] = '{0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h40, 1, 32'hCAFEF00D, 1, 0, 4'hF, 32'h40,  32'h0,        0, 32'h0,        1, 32'hCAFEF00D, 0};
      vecs[12] = '{0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[13] = '{0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h80, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[14] = '{0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h80,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[15] = '{0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,  1, 32'h55,       1, 0, 4'hF, 32'h80,  32'h0,        0, 32'h0,        1, 32'h55,       0};
      vecs[16] = '{0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};

      // Reset: requests are ignored and all outputs stay 0.
      rst_n = 1'b0;
      drive(1, 1, 4'hF, 32'hFFF0, 32'h1, 1, 32'hFFF4, 1, 32'h77);
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", pack_got(), 160'b0);
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].d_req, vecs[i].d_wr, vecs[i].d_sel, vecs[i].d_addr, vecs[i].d_wdata,
               vecs[i].i_req, vecs[i].i_addr, vecs[i].mv, vecs[i].mrd);
         #1;
         check($sformatf("vec%0d", i), pack_got(), pack_exp(vecs[i]));
      end

      // Silent memory: error completion on the 16th BUSY cycle with rdata forced to 0.
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h300, 32'h0, 0, 32'h0, 0, 32'h99999999);
      quiet_ok = 1'b1;
      for (int b = 1; b <= 15; b++) begin
         @(negedge clk);
         #1;
         if (!bus.o_mem_req || bus.o_d_valid || bus.o_i_valid || bus.o_err) quiet_ok = 1'b0;
      end
      check("timeout_quiet", {159'b0, quiet_ok}, 160'd1);
      @(negedge clk);
      #1;
      check("timeout_fire", {90'b0, bus.o_mem_req, bus.o_d_valid, bus.o_err, bus.o_i_valid, bus.o_d_rdata, 32'b0},
            {90'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'b0});
      @(negedge clk);
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
      #1;
      check("timeout_idle", {157'b0, bus.o_mem_req, bus.o_d_valid, bus.o_err}, 160'b0);

      // Memory valid on the expiry cycle counts as a normal completion.
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h304, 32'h0, 0, 32'h0, 0, 32'h0);
      repeat (15) @(negedge clk);
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h304, 32'h0, 0, 32'h0, 1, 32'h77);
      #1;
      check("timeout_race", {126'b0, bus.o_d_valid, bus.o_err, bus.o_d_rdata}, {126'b0, 1'b1, 1'b0, 32'h77});
      @(negedge clk);
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

      // Async reset in the 2nd BUSY cycle drops the transaction.
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h400, 32'h0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      #1;
      check("rst_busy1", {127'b0, bus.o_mem_req, bus.o_mem_addr}, {127'b0, 1'b1, 32'h400});
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h400, 32'h0, 0, 32'h0, 1, 32'h88);
      rst_n = 1'b0;
      #1;
      check("rst_drop", {156'b0, bus.o_mem_req, bus.o_d_valid, bus.o_i_valid, bus.o_err}, 160'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 4'hF, 32'h500, 32'h0, 0, 32'h0, 0, 32'h0);
      #1;
      check("rst_release", {159'b0, bus.o_mem_req}, 160'b0);
      @(negedge clk);
      #1;
      check("rst_regrant", {127'b0, bus.o_mem_req, bus.o_mem_addr}, {127'b0, 1'b1, 32'h500});
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h500, 32'h0, 0, 32'h0, 1, 32'h12345678);
      #1;
      check("rst_complete", {127'b0, bus.o_d_valid, bus.o_d_rdata}, {127'b0, 1'b1, 32'h12345678});
      @(negedge clk);
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

      // D and I both held: grant order depends on the starvation guard.
      @(negedge clk);
      drive(1, 0, 4'hF, 32'h1000, 32'h0, 1, 32'h2000, 0, 32'h0);
      g = 0;
      for (int cyc = 0; cyc < 60 && g < 10; cyc++) begin
         @(negedge clk);
         if (bus.o_mem_req) begin
            exp_i = GUARD && ((g % 5) == 4);
            check($sformatf("grant%0d_is_i", g), {159'b0, bus.o_mem_addr == 32'h2000}, {159'b0, exp_i});
            g++;
            bus.i_mem_valid = 1'b1;
            bus.i_mem_rdata = 32'(g);
         end else begin
            bus.i_mem_valid = 1'b0;
         end
      end
      if (g < 10) begin
         failures++;
         $display("FAIL grant_budget got=%0d exp=10", g);
      end
      @(negedge clk);
      drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
